// File: rtl/cache_types.sv
// Shared cache definitions.
//   pf_state_e      : prefetch responder states (IDLE, REQ, BEAT, RESP)
//   LINE_ALIGN_MASK : clears the byte offset of a 32-byte cache line
//   line_align()    : applies LINE_ALIGN_MASK to a byte address
package cache_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BEAT = 2'd2,
        RESP = 2'd3
    } pf_state_e;

    localparam logic [31:0] LINE_ALIGN_MASK = ~32'h1F;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & LINE_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pf_pending_slot.sv
// One-entry pending prefetch slot.
//   clk, rst   : clock, asynchronous active-low reset
//   load       : store load_addr and mark valid (newest address wins)
//   load_addr  : line-aligned address to store
//   clear      : drop the stored entry
//   cmp_addr   : address compared against the stored entry
//   valid      : slot holds an address
//   addr       : stored address
//   match      : valid and addr == cmp_addr
module pf_pending_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic        clear,
    input  logic [31:0] cmp_addr,
    output logic        valid,
    output logic [31:0] addr,
    output logic        match
);

    // load beats clear: when the slot is drained into the active fetch and a
    // new prefetch arrives on the same edge, the new one must be retained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            addr  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    assign match = valid && (addr == cmp_addr);

endmodule

// File: rtl/prefetch_responder.sv
// Prefetch responder: fetches one cache line from memory as NB beats and
// returns it to the cache, holding it until acknowledged.
//   clk, rst                        : clock, asynchronous active-low reset
//   prefetch, prefetch_addr         : request strobe and byte address
//   prefetch_ack                    : cache consumed the returned line
//   prefetch_rdata, prefetch_rvalid : assembled line, held until ack
//   busy                            : state is not IDLE
//   bmem_addr, bmem_read, bmem_ready: memory read request handshake
//   bmem_raddr, bmem_rdata, bmem_rvalid : returning beats tagged by line address
module prefetch_responder
    import cache_types::*;
#(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prefetch,
    input  logic [31:0]          prefetch_addr,
    input  logic                 prefetch_ack,
    output logic [LINE_BITS-1:0] prefetch_rdata,
    output logic                 prefetch_rvalid,
    output logic                 busy,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);

    localparam int NB = LINE_BITS / BEAT_BITS;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    pf_state_e            state, state_n;
    logic [31:0]          cur_addr, cur_n;
    logic                 cur_we;
    logic [CW-1:0]        cnt;
    logic [LINE_BITS-1:0] line;

    logic [31:0] pf_aligned;
    logic        pend_valid, pend_match;
    logic [31:0] pend_addr;
    logic        dup, pf_new, beat_acc, slot_load, slot_clear;

    assign pf_aligned = line_align(prefetch_addr);
    // A request already being served (or already queued) is dropped. While
    // leaving RESP the comparison is still against the outgoing line.
    assign dup        = ((state != IDLE) && (pf_aligned == cur_addr)) || pend_match;
    assign pf_new     = prefetch && !dup;
    // Beats for other lines share the return bus; only our tag is taken.
    assign beat_acc   = (state == BEAT) && bmem_rvalid && (bmem_raddr == cur_addr);

    pf_pending_slot u_pend (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .load_addr (pf_aligned),
        .clear     (slot_clear),
        .cmp_addr  (pf_aligned),
        .valid     (pend_valid),
        .addr      (pend_addr),
        .match     (pend_match)
    );

    always_comb begin
        state_n    = state;
        cur_we     = 1'b0;
        cur_n      = cur_addr;
        slot_load  = 1'b0;
        slot_clear = 1'b0;
        case (state)
            IDLE: begin
                if (prefetch) begin
                    state_n = REQ;
                    cur_we  = 1'b1;
                    cur_n   = pf_aligned;
                end
            end
            REQ: begin
                if (bmem_ready) state_n = BEAT;
                slot_load = pf_new;
            end
            BEAT: begin
                if (beat_acc && (cnt == CW'(NB - 1))) state_n = RESP;
                slot_load = pf_new;
            end
            RESP: begin
                if (prefetch_ack) begin
                    if (pend_valid) begin
                        // queued line goes next; a fresh request refills the slot
                        state_n    = REQ;
                        cur_we     = 1'b1;
                        cur_n      = pend_addr;
                        slot_clear = 1'b1;
                        slot_load  = pf_new;
                    end else if (pf_new) begin
                        // nothing queued: the fresh request is served directly
                        state_n = REQ;
                        cur_we  = 1'b1;
                        cur_n   = pf_aligned;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    slot_load = pf_new;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            cnt      <= '0;
            line     <= '0;
        end else begin
            state <= state_n;
            if (cur_we) cur_addr <= cur_n;
            if (state == REQ && bmem_ready) cnt <= '0;
            else if (beat_acc)              cnt <= cnt + 1'b1;
            if (beat_acc) line[BEAT_BITS*cnt +: BEAT_BITS] <= bmem_rdata;
        end
    end

    assign prefetch_rdata  = line;
    assign prefetch_rvalid = (state == RESP);
    assign busy            = (state != IDLE);
    assign bmem_addr       = cur_addr;
    assign bmem_read       = (state == REQ);

endmodule

// File: tb/tb_prefetch_responder.sv
module tb_prefetch_responder;

    localparam int LB = 256;
    localparam int BB = 64;
    localparam int NB = LB / BB;

    logic          clk = 1'b0;
    logic          rst;
    logic          prefetch;
    logic [31:0]   prefetch_addr;
    logic          prefetch_ack;
    logic [LB-1:0] prefetch_rdata;
    logic          prefetch_rvalid;
    logic          busy;
    logic [31:0]   bmem_addr;
    logic          bmem_read;
    logic          bmem_ready;
    logic [31:0]   bmem_raddr;
    logic [BB-1:0] bmem_rdata;
    logic          bmem_rvalid;

    always #5 clk = ~clk;

    prefetch_responder #(.LINE_BITS(LB), .BEAT_BITS(BB)) dut (
        .clk(clk), .rst(rst),
        .prefetch(prefetch), .prefetch_addr(prefetch_addr), .prefetch_ack(prefetch_ack),
        .prefetch_rdata(prefetch_rdata), .prefetch_rvalid(prefetch_rvalid), .busy(busy),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_ready(bmem_ready),
        .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // transaction-level model: line being served, queued line, progress
    bit          chk_en = 0;
    bit          m_busy, m_pv, m_hs;
    logic [31:0] m_cur, m_pend;
    int          m_beats;

    // memory model: one-cycle read latency, optional stall and foreign beats
    typedef struct { bit v; logic [31:0] a; logic [BB-1:0] d; } beat_t;
    beat_t       bq[$];
    logic [31:0] flog[$];
    int          stall_cfg = 0, stall_left = 0;
    bit          foreign_cfg = 0;

    function automatic logic [BB-1:0] beat_of(input logic [31:0] a, input int k);
        return {a ^ 32'h1220, 32'(k + 10)};
    endfunction

    function automatic logic [LB-1:0] line_of(input logic [31:0] a);
        logic [LB-1:0] l;
        for (int k = 0; k < NB; k++) l[BB*k +: BB] = beat_of(a, k);
        return l;
    endfunction

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst) begin
            check("busy", busy, m_busy);
            check("rvalid", prefetch_rvalid, m_busy && (m_beats == NB));
            check("bmem_read", bmem_read, m_busy && !m_hs);
            if (m_busy) check("bmem_addr", bmem_addr, m_cur);
            if (prefetch_rvalid) check("rdata", prefetch_rdata, line_of(m_cur));
        end
    end

    task automatic start_line(input logic [31:0] a);
        m_cur = a; m_busy = 1; m_hs = 0; m_beats = 0;
    endtask

    // one clock: observe pre-edge inputs, advance model, drive memory side
    task automatic tick();
        logic        hs, pf, ex, bok, dup;
        logic [31:0] hs_a, pa;
        beat_t       b;
        hs   = bmem_read && bmem_ready;
        hs_a = bmem_addr;
        pf   = prefetch;
        pa   = prefetch_addr & 32'hFFFF_FFE0;
        ex   = m_busy && (m_beats == NB) && prefetch_ack;
        bok  = bmem_rvalid && m_busy && m_hs && (bmem_raddr == m_cur);
        @(posedge clk);
        #1;
        cyc++;
        if (hs) m_hs = 1;
        if (bok) m_beats++;
        if (!m_busy) begin
            if (pf) start_line(pa);
        end else begin
            dup = pf && ((pa == m_cur) || (m_pv && pa == m_pend));
            if (ex) begin
                if (m_pv) begin
                    start_line(m_pend);
                    m_pv = 0;
                    if (pf && !dup) begin m_pend = pa; m_pv = 1; end
                end else if (pf && !dup) start_line(pa);
                else m_busy = 0;
            end else if (pf && !dup) begin
                m_pend = pa; m_pv = 1;
            end
        end
        if (hs) begin
            flog.push_back(hs_a);
            bq.push_back('{0, 32'h0, '0});
            for (int k = 0; k < NB; k++) begin
                bq.push_back('{1, hs_a, beat_of(hs_a, k)});
                if (foreign_cfg && k < NB-1) bq.push_back('{1, 32'h4000, 64'hDEAD_BEEF});
            end
        end
        if (bq.size() > 0) begin
            b = bq.pop_front();
            bmem_rvalid = b.v; bmem_raddr = b.a; bmem_rdata = b.d;
        end else begin
            bmem_rvalid = 0; bmem_raddr = 0; bmem_rdata = 0;
        end
        if (bmem_read) begin
            if (stall_left > 0) begin bmem_ready = 0; stall_left--; end
            else bmem_ready = 1;
        end else begin
            bmem_ready = 0; stall_left = stall_cfg;
        end
    endtask

    task automatic wait_rv(input int c0, output int lat);
        int i;
        for (i = 0; i < 200 && !prefetch_rvalid; i++) tick();
        if (!prefetch_rvalid) check("rvalid_timeout", 0, 1);
        lat = cyc - c0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300 && busy; i++) tick();
        check("idle_timeout", busy, 0);
    endtask

    task automatic fetch(input logic [31:0] a, output int lat);
        int c0;
        prefetch = 1; prefetch_addr = a; c0 = cyc;
        tick();
        prefetch = 0;
        wait_rv(c0, lat);
    endtask

    task automatic ack();
        prefetch_ack = 1; tick(); prefetch_ack = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [LB-1:0] held;
        rst = 0; prefetch = 0; prefetch_addr = 0; prefetch_ack = 0;
        bmem_ready = 0; bmem_raddr = 0; bmem_rdata = 0; bmem_rvalid = 0;
        m_busy = 0; m_pv = 0; m_hs = 0; m_beats = 0; m_cur = 0; m_pend = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_rvalid", prefetch_rvalid, 0);
        check("rst_bmem_read", bmem_read, 0);
        check("rst_bmem_addr", bmem_addr, 0);
        check("rst_rdata", prefetch_rdata, 0);
        rst = 1; chk_en = 1;
        tick();

        // single fetch, immediate ready
        flog.delete();
        prefetch = 1; prefetch_addr = 32'h0000_1234;
        begin
            int c0; c0 = cyc;
            tick(); prefetch = 0;
            check("single_bmem_addr", bmem_addr, 32'h1220);
            check("single_bmem_read", bmem_read, 1);
            wait_rv(c0, lat);
        end
        check("single_latency", lat, 7);
        check("single_rdata", prefetch_rdata,
              256'h000000000000000D_000000000000000C_000000000000000B_000000000000000A);
        ack();
        check("single_idle_after_ack", busy, 0);
        tick();

        // stalled handshake
        stall_cfg = 5; stall_left = 5;
        fetch(32'h0000_2044, lat);
        check("stall_latency", lat, 12);
        stall_cfg = 0;
        ack(); tick();

        // foreign beats interleaved
        foreign_cfg = 1;
        fetch(32'h0000_1234, lat);
        check("foreign_latency", lat, 10);
        foreign_cfg = 0;
        ack(); tick();

        // pending + duplicate filter; ack held high also outside RESP
        flog.delete();
        prefetch_ack = 1;
        prefetch = 1; prefetch_addr = 32'h1000; tick();
        prefetch = 0; tick();
        prefetch = 1; prefetch_addr = 32'h2000; tick();
        prefetch_addr = 32'h3000; tick();
        prefetch_addr = 32'h1004; tick();
        prefetch = 0;
        wait_idle();
        prefetch_ack = 0;
        check("pend_fetch_count", flog.size(), 2);
        if (flog.size() == 2) begin
            check("pend_fetch0", flog[0], 32'h1000);
            check("pend_fetch1", flog[1], 32'h3000);
        end
        tick();

        // ack withheld for 10 cycles
        fetch(32'h0000_7777, lat);
        held = prefetch_rdata;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_rvalid", prefetch_rvalid, 1);
            check("hold_rdata", prefetch_rdata, held);
        end
        ack();
        check("hold_idle_after_ack", busy, 0);
        check("hold_rvalid_dropped", prefetch_rvalid, 0);
        tick();

        // prefetch on the exit edge: new address served directly; a duplicate goes idle
        fetch(32'h0000_8000, lat);
        prefetch_ack = 1; prefetch = 1; prefetch_addr = 32'h9010;
        tick();
        prefetch_ack = 0; prefetch = 0;
        check("exit_new_read", bmem_read, 1);
        check("exit_new_addr", bmem_addr, 32'h9000);
        wait_rv(cyc, lat);
        prefetch_ack = 1; prefetch = 1; prefetch_addr = 32'h9008;
        tick();
        prefetch_ack = 0; prefetch = 0;
        check("exit_dup_idle", busy, 0);
        tick();

        // reset after two beats: partial line discarded
        prefetch = 1; prefetch_addr = 32'h0000_5678; tick(); prefetch = 0;
        for (int i = 0; i < 50 && m_beats < 2; i++) tick();
        #1;
        rst = 0;
        bq.delete();
        bmem_rvalid = 0; bmem_raddr = 0; bmem_rdata = 0; bmem_ready = 0;
        m_busy = 0; m_pv = 0; m_hs = 0; m_beats = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rvalid", prefetch_rvalid, 0);
        check("mid_rst_bmem_read", bmem_read, 0);
        check("mid_rst_bmem_addr", bmem_addr, 0);
        check("mid_rst_rdata", prefetch_rdata, 0);
        tick(); tick();
        rst = 1;
        tick();
        fetch(32'h0000_1234, lat);
        check("post_rst_latency", lat, 7);
        check("post_rst_rdata", prefetch_rdata,
              256'h000000000000000D_000000000000000C_000000000000000B_000000000000000A);
        ack();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
